// File: rtl/trace_capture_buffer.sv
// Purpose : capture buffer for retired-instruction and trap events of the RV32I core.
//           Stream mode is a drop-when-full FIFO. Trigger mode keeps the newest DEPTH
//           entries, freezes POST_TRIG entries after a trap, then lets the reader drain.
// Latency : an entry written at edge N is visible on rd_valid/rd_data right after edge N.
//           The head entry is read combinationally (first-word fall-through).
// Backpr. : valid/ready readout. Stream mode drops new events when full and counts them
//           in ovf_cnt. Trigger mode overwrites the oldest entry and counts the overwrite.
// Ports   : clk/rst        clock, synchronous active-high reset
//           commit_*       WB-stage retire info; trap_* from the CSR unit
//           arm/mode       clear and start capture, latching mode (0=stream, 1=trigger)
//           rd_valid/rd_ready/rd_data  head-entry readout
//           level/ovf_cnt/state        stored count, saturating drop count, FSM state
module trace_capture_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_inst,
  input  logic                     commit_rf_we,
  input  logic [4:0]               commit_rd,
  input  logic [XLEN-1:0]          commit_wdata,
  input  logic                     trap_valid,
  input  logic [XLEN-1:0]          trap_epc,
  input  logic [XLEN-1:0]          trap_cause,
  input  logic                     arm,
  input  logic                     mode,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [3*XLEN+6:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [1:0]               state
);

  localparam int EW = 3*XLEN + 7;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_FROZEN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q;
  logic [AW-1:0]     head_q, tail_q;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     post_q, post_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic              cap_en;
  logic              full;
  logic              pop;
  logic              acc;
  logic              wr;
  logic              overwrite;
  logic              head_adv;
  logic [1:0]        ovf_inc;
  logic [CNT_W:0]    ovf_sum;
  logic [XLEN-1:0]   inst_ext;
  logic [EW-1:0]     entry;

  // ---------------------------------------------------------------- datapath comb
  assign inst_ext = XLEN'(commit_inst);

  // A trap wins the single write slot; a coincident commit is lost and counted.
  assign entry = trap_valid ? {1'b1, trap_epc, trap_cause, 5'd0, 1'b0, {XLEN{1'b0}}}
                            : {1'b0, commit_pc, inst_ext, commit_rd, commit_rf_we, commit_wdata};

  assign full      = (level_q == LW'(DEPTH));
  assign pop       = rd_valid & rd_ready;
  // Events in the arm cycle are discarded without being counted.
  assign acc       = cap_en & (commit_valid | trap_valid) & ~arm;
  // Stream accepts when there is room or the head leaves this cycle; trigger always writes.
  assign wr        = acc & (mode_q | ~full | pop);
  assign overwrite = wr & full & mode_q;
  assign head_adv  = pop | overwrite;

  assign ovf_inc = {1'b0, acc & commit_valid & trap_valid}
                 + {1'b0, acc & ~wr}
                 + {1'b0, overwrite};
  assign ovf_sum = {1'b0, ovf_q} + (CNT_W+1)'(ovf_inc);
  assign ovf_d   = ovf_sum[CNT_W] ? {CNT_W{1'b1}} : ovf_sum[CNT_W-1:0];

  assign level_d = level_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, head_adv};

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (arm) begin
      state_d = S_CAPTURE;
      post_d  = '0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          // wr with trap_valid means the trap itself was the entry written.
          if (wr && mode_q && trap_valid) begin
            if (POST_TRIG == 0) begin
              state_d = S_FROZEN;
            end else begin
              state_d = S_POST;
              post_d  = LW'(POST_TRIG);
            end
          end
        end
        S_POST: begin
          if (wr) begin
            post_d = post_q - LW'(1);
            if (post_q == LW'(1)) begin
              state_d = S_FROZEN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    cap_en   = 1'b0;
    rd_valid = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        cap_en   = 1'b1;
        rd_valid = ~mode_q & (level_q != '0);
      end
      S_POST:   cap_en   = 1'b1;
      S_FROZEN: rd_valid = (level_q != '0);
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= '0;
      post_q  <= '0;
    end else if (arm) begin
      mode_q  <= mode;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= '0;
      post_q  <= '0;
    end else begin
      post_q  <= post_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (wr) begin
        tail_q <= tail_q + AW'(1);
      end
      if (head_adv) begin
        head_q <= head_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; rd_data is only meaningful while rd_valid is high.
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem_q[tail_q] <= entry;
    end
  end

  assign rd_data = mem_q[head_q];
  assign level   = level_q;
  assign ovf_cnt = ovf_q;
  assign state   = state_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Purpose : self-checking bench for trace_capture_buffer (DEPTH=4, POST_TRIG=2, CNT_W=4)
//           with a second instance using POST_TRIG=0 for the immediate-freeze case.
// Latency : checks are sampled 1 time unit after each rising edge.
// Backpr. : rd_ready is driven directly by the directed steps and the random phase.
module tb_trace_capture_buffer;

  localparam int XLEN = 32;
  localparam int D    = 4;
  localparam int PT   = 2;
  localparam int CW   = 4;
  localparam int EW   = 3*XLEN + 7;
  localparam int OMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst, commit_valid, commit_rf_we, trap_valid, arm, mode, rd_ready;
  logic [31:0]     commit_pc, commit_inst, commit_wdata, trap_epc, trap_cause;
  logic [4:0]      commit_rd;
  logic            rd_valid, rd_valid0;
  logic [EW-1:0]   rd_data, rd_data0;
  logic [2:0]      level, level0;
  logic [CW-1:0]   ovf_cnt, ovf_cnt0;
  logic [1:0]      state, state0;

  int errors = 0;
  int checks = 0;

  // Reference model: entry list plus phase (0 idle, 1 capture, 2 post, 3 frozen).
  logic [EW-1:0] mq[$];
  int            phase = 0;
  int            post  = 0;
  int            movf  = 0;
  bit            mmode = 1'b0;

  always #5 clk = ~clk;

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(D), .POST_TRIG(PT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rf_we(commit_rf_we), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_cause(trap_cause),
    .arm(arm), .mode(mode),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .ovf_cnt(ovf_cnt), .state(state)
  );

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(D), .POST_TRIG(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rf_we(commit_rf_we), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_cause(trap_cause),
    .arm(arm), .mode(mode),
    .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0),
    .level(level0), .ovf_cnt(ovf_cnt0), .state(state0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_rdv();
    return (mq.size() != 0) && ((phase == 1 && mmode == 1'b0) || phase == 3);
  endfunction

  // Applies the behavioural rules to the inputs present before the coming edge.
  task automatic model_step();
    bit            pop;
    int            drops;
    logic [EW-1:0] e;
    pop = model_rdv() && rd_ready;
    if (rst) begin
      mq.delete(); phase = 0; post = 0; movf = 0; mmode = 1'b0;
    end else if (arm) begin
      mq.delete(); phase = 1; post = 0; movf = 0; mmode = mode;
    end else begin
      if (pop) void'(mq.pop_front());
      if ((phase == 1 || phase == 2) && (commit_valid || trap_valid)) begin
        drops = (commit_valid && trap_valid) ? 1 : 0;
        e = trap_valid ? {1'b1, trap_epc, trap_cause, 5'd0, 1'b0, 32'd0}
                       : {1'b0, commit_pc, commit_inst, commit_rd, commit_rf_we, commit_wdata};
        if (!mmode) begin
          if (mq.size() < D) mq.push_back(e);
          else drops++;
        end else begin
          if (mq.size() == D) begin
            void'(mq.pop_front());
            drops++;
          end
          mq.push_back(e);
          if (phase == 1 && trap_valid) begin
            if (PT == 0) phase = 3;
            else begin phase = 2; post = PT; end
          end else if (phase == 2) begin
            post--;
            if (post == 0) phase = 3;
          end
        end
        movf = (movf + drops > OMAX) ? OMAX : movf + drops;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("state", state, phase);
    chk("level", level, mq.size());
    chk("ovf_cnt", ovf_cnt, movf);
    chk("rd_valid", rd_valid, model_rdv());
    if (model_rdv()) chk("rd_data", rd_data, mq[0]);
  endtask

  task automatic do_commit(input logic [31:0] pc);
    commit_valid = 1'b1; commit_pc = pc; commit_inst = $urandom;
    commit_rd = 5'($urandom); commit_rf_we = 1'($urandom); commit_wdata = $urandom;
    cycle();
    commit_valid = 1'b0;
  endtask

  task automatic do_trap(input logic [31:0] epc, input logic [31:0] cause);
    trap_valid = 1'b1; trap_epc = epc; trap_cause = cause;
    cycle();
    trap_valid = 1'b0;
  endtask

  task automatic do_arm(input logic m);
    arm = 1'b1; mode = m;
    cycle();
    arm = 1'b0; mode = ~m;
  endtask

  task automatic pop_pc(input logic [31:0] pc);
    chk("drain_vld", rd_valid, 1'b1);
    chk("drain_pc", rd_data[101:70], pc);
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; mode = 1'b0; rd_ready = 1'b0;
    commit_valid = 1'b0; trap_valid = 1'b0;
    commit_pc = '0; commit_inst = '0; commit_rd = '0; commit_rf_we = 1'b0; commit_wdata = '0;
    trap_epc = '0; trap_cause = '0;
    cycle();
    cycle();
    chk("rst_state", state, 2'd0);
    chk("rst_level", level, 3'd0);
    chk("rst_rdv", rd_valid, 1'b0);
    rst = 1'b0;

    // 1: stream overflow then in-order drain; arm right at reset release
    do_arm(1'b0);
    for (int i = 0; i < 6; i++) do_commit(32'(i * 4));
    chk("t1_level", level, 3'd4);
    chk("t1_ovf", ovf_cnt, 4'd2);
    for (int i = 0; i < 4; i++) pop_pc(32'(i * 4));
    chk("t1_empty", rd_valid, 1'b0);

    // 2: pop and write in the same cycle while full
    for (int i = 0; i < 4; i++) do_commit(32'h20 + 32'(i * 4));
    rd_ready = 1'b1;
    do_commit(32'h40);
    rd_ready = 1'b0;
    chk("t2_level", level, 3'd4);
    chk("t2_ovf", ovf_cnt, 4'd2);
    // saturation of the drop counter
    for (int i = 0; i < 20; i++) do_commit(32'h80);
    chk("sat_ovf", ovf_cnt, 4'hF);
    pop_pc(32'h24); pop_pc(32'h28); pop_pc(32'h2C); pop_pc(32'h40);

    // 4: trap+commit collision in stream, arm discards a coincident commit
    do_arm(1'b0);
    commit_valid = 1'b1; commit_pc = 32'h300;
    do_trap(32'h300, 32'h7);
    commit_valid = 1'b0;
    chk("t4_level", level, 3'd1);
    chk("t4_ovf", ovf_cnt, 4'd1);
    chk("t4_kind", rd_data[102], 1'b1);
    commit_valid = 1'b1; commit_pc = 32'h304;
    do_arm(1'b0);
    commit_valid = 1'b0;
    chk("t4_arm_level", level, 3'd0);

    // 3: trigger mode, wrap, trap, post window, freeze, drain
    do_arm(1'b1);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) do_commit(32'h100 + 32'(i * 4));
    chk("t3_rdv_capture", rd_valid, 1'b0);
    do_trap(32'h110, 32'h2);
    chk("t3_post", state, 2'd2);
    do_commit(32'h200);
    do_commit(32'h204);
    chk("t3_frozen", state, 2'd3);
    rd_ready = 1'b0;
    do_commit(32'h208);
    chk("t3_level", level, 3'd4);
    chk("t3_ovf", ovf_cnt, 4'd4);
    chk("t3_k0", rd_data[102], 1'b0);
    pop_pc(32'h110);
    chk("t3_k1", rd_data[102], 1'b1);
    chk("t3_cause", rd_data[69:38], 32'h2);
    pop_pc(32'h110);
    pop_pc(32'h200);
    pop_pc(32'h204);
    chk("t3_empty", rd_valid, 1'b0);
    chk("t3_stay", state, 2'd3);

    // 5: reset in the middle of the post window
    do_arm(1'b1);
    do_commit(32'h500);
    do_commit(32'h504);
    do_trap(32'h508, 32'h3);
    chk("t5_post", state, 2'd2);
    chk("t5_level", level, 3'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_state", state, 2'd0);
    chk("t5_lvl", level, 3'd0);
    chk("t5_ovf", ovf_cnt, 4'd0);
    chk("t5_rdv", rd_valid, 1'b0);
    do_commit(32'h600);
    do_commit(32'h604);
    chk("t5_ignored", level, 3'd0);

    // 6: POST_TRIG=0 instance freezes on the first trap
    do_arm(1'b1);
    do_trap(32'h700, 32'hB);
    chk("t6_state", state0, 2'd3);
    chk("t6_level", level0, 3'd1);
    chk("t6_rdv", rd_valid0, 1'b1);
    chk("t6_kind", rd_data0[102], 1'b1);
    do_commit(32'h704);
    chk("t6_frozen_level", level0, 3'd1);

    // randomized traffic, both modes, occasional arm/reset
    for (int r = 0; r < 4; r++) begin
      do_arm(1'(r));
      for (int i = 0; i < 200; i++) begin
        commit_valid = ($urandom_range(99) < 60);
        trap_valid   = ($urandom_range(99) < 8);
        commit_pc    = $urandom; commit_inst = $urandom; commit_wdata = $urandom;
        commit_rd    = 5'($urandom); commit_rf_we = 1'($urandom);
        trap_epc     = $urandom; trap_cause = $urandom;
        rd_ready     = 1'($urandom);
        mode         = 1'($urandom);
        arm          = ($urandom_range(99) < 2);
        rst          = ($urandom_range(99) < 1);
        cycle();
      end
      commit_valid = 1'b0; trap_valid = 1'b0; arm = 1'b0; rst = 1'b0; rd_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
